// File: rtl/shift_seq_pkg.sv
// Shared types and default sizes for the multi-cycle shift sequencer.
package shift_seq_pkg;

  localparam int unsigned WIDTH_DEF   = 8;
  localparam int unsigned SHAMT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response and shift-unit bundle between the sequencer and its surroundings.
interface shift_sequencer_if
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
);

  logic               Start;
  logic [WIDTH-1:0]   Operand;
  logic [SHAMT_W-1:0] Shamt;
  logic [WIDTH-1:0]   ShSource;
  logic               ShEnable;
  logic [WIDTH-1:0]   ShResult;
  logic               Busy;
  logic               Done;
  logic [WIDTH-1:0]   Result;
  logic               Carry;

  // Environment side: issues requests and returns the shift unit result
  modport master (
    output Start, Operand, Shamt, ShResult,
    input  ShSource, ShEnable, Busy, Done, Result, Carry
  );

  // Sequencer side
  modport slave (
    input  Start, Operand, Shamt, ShResult,
    output ShSource, ShEnable, Busy, Done, Result, Carry
  );

endinterface

// File: rtl/shift_sequencer.sv
// Drives a 1-bit shift unit for Shamt passes, turning one request into a
// multi-bit left shift with the last bit shifted out reported as Carry.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  shift_sequencer_if.slave   bus
);

  seq_state_t         state_q, state_d;
  logic [WIDTH-1:0]   w_q, w_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               shen_q, shen_d;

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      w_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      shen_q   <= shen_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          w_d     = bus.Operand;
          cnt_d   = bus.Shamt;
          carry_d = 1'b0;
          state_d = (bus.Shamt == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        w_d     = bus.ShResult;
        carry_d = w_q[WIDTH-1];
        cnt_d   = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Result is captured on entry to DONE so it is already valid with the pulse
    if (state_d == DONE) begin
      result_d = w_d;
    end
  end

  // Status flags registered from the upcoming state
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    shen_d = (state_d == RUN);
  end

  assign bus.ShSource = w_q;
  assign bus.ShEnable = shen_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Result   = result_q;
  assign bus.Carry    = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: sequencer plus a behavioural 1-bit shift unit, compared
// against a whole-operation arithmetic model of each request.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int unsigned W  = WIDTH_DEF;
  localparam int unsigned SW = SHAMT_W_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  shift_sequencer #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  // 1-bit shift unit: zero fill from the LSB when enabled
  assign bus.ShResult = bus.ShEnable ? {bus.ShSource[W-2:0], 1'b0} : bus.ShSource;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] held_res = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Issue one request (caller is at a negedge) and follow it to the first IDLE cycle
  task automatic run_op(input logic [W-1:0] op, input logic [SW-1:0] sh, input bit repulse);
    logic [2*W-1:0] wide;
    logic [W-1:0]   exp_res;
    logic [W-1:0]   exp_src;
    logic           exp_c;
    int             n;
    n       = int'(sh);
    wide    = (2*W)'(op) << n;
    exp_res = wide[W-1:0];
    exp_c   = (n == 0) ? 1'b0 : wide[W];

    bus.Start   = 1'b1;
    bus.Operand = op;
    bus.Shamt   = sh;
    @(posedge clk);
    #1;
    bus.Start   = 1'b0;
    bus.Operand = W'($urandom);
    bus.Shamt   = SW'($urandom);

    for (int cyc = 1; cyc <= n + 2; cyc++) begin
      @(negedge clk);
      wide    = (2*W)'(op) << (cyc - 1);
      exp_src = wide[W-1:0];
      check_eq("shen", 32'(bus.ShEnable), 32'(cyc <= n));
      if (cyc <= n) check_eq("src", 32'(bus.ShSource), 32'(exp_src));
      check_eq("busy", 32'(bus.Busy), 32'(cyc <= n + 1));
      check_eq("done", 32'(bus.Done), 32'(cyc == n + 1));
      if (cyc <= n) begin
        check_eq("held_res", 32'(bus.Result), 32'(held_res));
      end else begin
        check_eq("res", 32'(bus.Result), 32'(exp_res));
        check_eq("carry", 32'(bus.Carry), 32'(exp_c));
      end
      bus.Start = repulse && (cyc == 2);
      if (repulse && (cyc == 2)) begin
        bus.Operand = W'(1);
        bus.Shamt   = SW'(1);
      end
    end
    held_res = exp_res;
  endtask

  // Abort an operation mid-RUN with reset, then confirm nothing completes
  task automatic reset_mid();
    bus.Start   = 1'b1;
    bus.Operand = W'(8'hFF);
    bus.Shamt   = SW'(5);
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rm_busy", 32'(bus.Busy), 32'(1));
    check_eq("rm_shen", 32'(bus.ShEnable), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rm_busy0", 32'(bus.Busy), 32'(0));
    check_eq("rm_done0", 32'(bus.Done), 32'(0));
    check_eq("rm_res0", 32'(bus.Result), 32'(0));
    check_eq("rm_carry0", 32'(bus.Carry), 32'(0));
    check_eq("rm_shen0", 32'(bus.ShEnable), 32'(0));
    check_eq("rm_src0", 32'(bus.ShSource), 32'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    held_res = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("rm_nodone", 32'(bus.Done), 32'(0));
      check_eq("rm_idle", 32'(bus.Busy), 32'(0));
    end
  endtask

  initial begin
    bus.Start   = 1'b0;
    bus.Operand = '0;
    bus.Shamt   = '0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(bus.Busy), 32'(0));
    check_eq("rst_done", 32'(bus.Done), 32'(0));
    check_eq("rst_res", 32'(bus.Result), 32'(0));
    check_eq("rst_carry", 32'(bus.Carry), 32'(0));
    check_eq("rst_shen", 32'(bus.ShEnable), 32'(0));
    check_eq("rst_src", 32'(bus.ShSource), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op(W'(8'h81), SW'(1), 1'b0);
    run_op(W'(8'h5A), SW'(0), 1'b0);
    run_op(W'(8'hB5), SW'(3), 1'b0);
    run_op(W'(8'hFF), SW'(7), 1'b1);
    reset_mid();
    run_op(W'(8'hFF), SW'(5), 1'b0);
    run_op(W'(8'h03), SW'(2), 1'b0);
    run_op(W'(8'h40), SW'(1), 1'b0);

    for (int k = 0; k < 30; k++) begin
      logic [W-1:0]  op;
      logic [SW-1:0] sh;
      bit            rp;
      op = W'($urandom);
      sh = SW'($urandom_range(0, (1 << SW) - 1));
      rp = (int'(sh) >= 3) && ($urandom_range(0, 1) == 1);
      run_op(op, sh, rp);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
